// File: rtl/fifo_bram_pkg.sv
// Shared types and constants for the packet-FIFO read-side frame reader.
package fifo_bram_pkg;

    localparam int BRAM_DEPTH = 1024;
    // Skid entries carry {tlast, data}.
    localparam int SKID_W     = 9;

    function automatic int addr_bits(input int num_bram);
        return $clog2(num_bram * BRAM_DEPTH);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    // Descriptor layout for the default four-BRAM buffer.
    localparam int DESC_ADDR_W = 12;
    localparam int DESC_LEN_W  = 16;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0] addr;
        logic [DESC_LEN_W-1:0]  len;
    } desc_t;

endpackage

// File: rtl/fifo_bram_frame_reader_skid2.sv
// Two-entry fall-through skid FIFO: an arriving entry is presented the same cycle when empty.
module fifo_bram_skid2
    import fifo_bram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [SKID_W-1:0] wr_data,
    input  logic              pop_ready,
    output logic              out_valid,
    output logic [SKID_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [SKID_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic              empty;
    logic              pop;
    logic              store;
    logic              unload;

    always_comb begin
        empty     = (cnt == 2'd0);
        out_valid = !empty || wr_en;
        out_data  = '0;
        if (!empty)
            out_data = mem[rd_ptr];
        else if (wr_en)
            out_data = wr_data;
        pop    = out_valid && pop_ready;
        // A byte consumed on arrival bypasses storage entirely.
        store  = wr_en && !(empty && pop);
        unload = pop && !empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= !wr_ptr;
            end
            if (unload)
                rd_ptr <= !rd_ptr;
            cnt <= cnt + 2'(store) - 2'(unload);
        end
    end

    assign count = cnt;

endmodule

// File: rtl/fifo_bram_frame_reader.sv
// Frame reader: streams descriptor-addressed bytes from BRAM and returns the freed pointer.
// Optional running checksum output enabled by macro FRAME_READER_CSUM_EN.
module fifo_bram_frame_reader
    import fifo_bram_pkg::*;
#(
    parameter  int P_NUM_BRAM = 4,
    parameter  int P_LEN_BITS = 16,
    localparam int ADDR_BITS  = addr_bits(P_NUM_BRAM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ADDR_BITS-1:0]  desc_addr,
    input  logic [P_LEN_BITS-1:0] desc_len,
    output logic [ADDR_BITS-1:0]  bram_addr,
    input  logic [7:0]            bram_rd_data,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  frame_done,
    output logic [ADDR_BITS-1:0]  free_ptr,
    output logic                  busy,
    output state_t                dbg_state
`ifdef FRAME_READER_CSUM_EN
    ,
    output logic [15:0]           csum
`endif
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(P_NUM_BRAM * BRAM_DEPTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic                  armed;
    logic [ADDR_BITS-1:0]  rd_addr;
    logic [ADDR_BITS-1:0]  free_ptr_q;
    logic [P_LEN_BITS-1:0] remaining;
    logic                  rd_pend;
    logic                  rd_pend_last;
    logic                  accept;
    logic                  issue;
    logic                  stream_hs;
    logic                  tlast_hs;
    logic                  sk_valid;
    logic [SKID_W-1:0]     sk_data;
    logic [1:0]            sk_count;

    // Both handshakes transfer exactly on a cycle where valid && ready; valid, data and
    // tlast never change while valid is high and ready is low.
    assign stream_hs = sk_valid && m_axis_tready;
    assign tlast_hs  = stream_hs && sk_data[8];

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                accept = desc_valid && armed;
                if (accept)
                    state_nxt = (desc_len == '0) ? DONE : STREAM;
            end
            STREAM: begin
                // Count in-flight reads so the skid can never overflow.
                issue = (({1'b0, sk_count} + {2'b0, rd_pend}) < 3'd2) && (remaining != '0);
                if (tlast_hs)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            armed        <= 1'b0;
            rd_addr      <= '0;
            remaining    <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            free_ptr_q   <= '0;
        end else begin
            state        <= state_nxt;
            armed        <= 1'b1;
            rd_pend      <= issue;
            rd_pend_last <= issue && (remaining == P_LEN_BITS'(1));
            if (accept) begin
                rd_addr   <= desc_addr;
                remaining <= desc_len;
            end else if (issue) begin
                rd_addr   <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_BITS'(1);
                remaining <= remaining - P_LEN_BITS'(1);
            end
            // Load on entry to DONE so free_ptr is already valid during the frame_done pulse.
            if (state_nxt == DONE && state != DONE)
                free_ptr_q <= accept ? desc_addr : rd_addr;
        end
    end

    fifo_bram_skid2 u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (rd_pend),
        .wr_data   ({rd_pend_last, bram_rd_data}),
        .pop_ready (m_axis_tready),
        .out_valid (sk_valid),
        .out_data  (sk_data),
        .count     (sk_count)
    );

    assign desc_ready    = (state == IDLE) && armed;
    assign bram_addr     = rd_addr;
    assign m_axis_tvalid = sk_valid;
    assign m_axis_tdata  = sk_data[7:0];
    assign m_axis_tlast  = sk_data[8];
    assign frame_done    = (state == DONE);
    assign free_ptr      = free_ptr_q;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

`ifdef FRAME_READER_CSUM_EN
    logic        odd_byte;
    logic [15:0] csum_q;
    logic [15:0] term;
    logic [16:0] sum17;

    always_comb begin
        term  = odd_byte ? {8'h00, sk_data[7:0]} : {sk_data[7:0], 8'h00};
        sum17 = {1'b0, csum_q} + {1'b0, term};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q   <= '0;
            odd_byte <= 1'b0;
        end else if (accept) begin
            csum_q   <= '0;
            odd_byte <= 1'b0;
        end else if (stream_hs) begin
            csum_q   <= sum17[15:0] + 16'(sum17[16]);
            odd_byte <= !odd_byte;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: doc/fifo_bram_frame_reader.md
Name: fifo_bram_frame_reader

Overview:
- Read-side engine for the network-stack packet FIFO. Accepts frame descriptors (start address, byte length).
- Issues byte reads to the BRAM read port, which has 1-cycle read latency.
- Presents the bytes as an AXI-Stream-style byte stream with tlast.
- Reports the freed read pointer to the write-side logic once each frame is fully consumed.

Parameters:
- P_NUM_BRAM, 4, number of 1K x 8 BRAMs in the buffer; depth = P_NUM_BRAM*1024 bytes, ADDR_BITS = clog2(depth).
- P_LEN_BITS, 16, width of the descriptor length field.

Ports:
- clk  in  1  single clock, also drives the BRAM read port.
- rst_n  in  1  asynchronous, active-low reset.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  descriptor accepted when valid&ready.
- desc_addr  in  ADDR_BITS  first byte address of the frame.
- desc_len  in  P_LEN_BITS  frame length in bytes.
- bram_addr  out  ADDR_BITS  BRAM read address.
- bram_rd_data  in  8  BRAM read data, valid 1 cycle after bram_addr is presented.
- m_axis_tdata  out  8  stream byte.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  marks the final byte of the frame.
- frame_done  out  1  1-cycle pulse when a frame is fully consumed.
- free_ptr  out  ADDR_BITS  address one past the frame's last byte (modulo depth); held until the next frame_done.
- busy  out  1  high from descriptor accept until frame_done.

Behaviour:
- Reset values: desc_ready=0, m_axis_tvalid=0, m_axis_tlast=0, frame_done=0, free_ptr=0, busy=0, bram_addr=0, m_axis_tdata=0. The FSM returns to IDLE.
- Reset mid-frame: the frame is abandoned, the skid buffer is flushed, and no frame_done is generated.
- FSM IDLE:
  - desc_ready=1.
  - On accept, latch addr and len into rd_addr and remaining.
  - len=0 -> DONE with no stream output.
  - Otherwise -> STREAM.
- FSM STREAM:
  - A read is issued in any cycle where (skid occupancy + reads in flight) < 2 and remaining > 0.
  - Each issue drives bram_addr=rd_addr, sets rd_addr <= rd_addr+1 modulo depth (wraps at depth-1 -> 0), and decrements remaining.
  - Read data is captured into a 2-entry skid FIFO the cycle after issue.
  - The head of the skid FIFO drives m_axis_*.
  - The tlast flag is computed at issue time (remaining==1) and travels with the byte.
  - Exit to DONE on the handshake of the tlast byte.
- FSM DONE:
  - frame_done=1 for exactly one cycle.
  - free_ptr <= final rd_addr.
  - Then -> IDLE. The next descriptor can be accepted in the cycle after DONE.
- Latency:
  - From descriptor accept, the first bram_addr issue is the next cycle.
  - The first tvalid follows 2 cycles after accept.
  - With tready held high, throughput is 1 byte/cycle sustained with no bubbles.
- Backpressure:
  - tvalid, tdata and tlast stay stable while tready=0.
  - No byte is lost or duplicated.
  - Issue stalls when the skid FIFO is full, counting in-flight reads.
- Frames with len > depth wrap repeatedly. This is the caller's responsibility and is not checked.
- Descriptor handshake and stream handshake never occur in the same cycle (desc_ready=0 outside IDLE).

Optional Feature:
- Macro FRAME_READER_CSUM_EN.
- Defined:
  - Adds output csum (16 bit), a running 16-bit ones'-complement sum over the streamed bytes paired big-endian.
  - An odd final byte is padded with 0x00.
  - End-around carry is applied on each add.
  - csum is updated on each stream handshake and cleared on descriptor accept.
  - Its final value is valid when frame_done pulses, and it is held until the next accept.
- Undefined: the port and logic are absent, and all other behaviour is identical.

Decomposition:
- Package fifo_bram_pkg holds:
  - function/constant for ADDR_BITS from P_NUM_BRAM;
  - the FSM state enum (IDLE, STREAM, DONE);
  - the descriptor struct typedef {addr, len}.
- One natural sub-module, fifo_bram_skid2: the 2-entry skid FIFO carrying {tlast, data} with occupancy output.

Test Plan:
- Reset and single frame:
  - Stimulus: reset, then descriptor addr=0x010, len=4 with tready=1; BRAM preloaded 0xA0..0xA3.
  - Response: bytes A0,A1,A2,A3 on 4 consecutive cycles starting 2 cycles after accept, tlast on A3, then frame_done with free_ptr=0x014.
- Wrap-around:
  - Stimulus: P_NUM_BRAM=4, addr=0xFFE, len=4.
  - Response: reads issued at 0xFFE, 0xFFF, 0x000, 0x001; free_ptr=0x002.
- Backpressure:
  - Stimulus: len=8, tready toggled randomly at 50% duty.
  - Response: the exact 8-byte sequence, data stable while stalled, no more than 2 outstanding, tlast only on byte 8.
- Zero length:
  - Stimulus: descriptor with len=0 at addr=0x100.
  - Response: no tvalid; frame_done 1 cycle after accept; free_ptr=0x100.
- Reset mid-frame:
  - Stimulus: assert rst_n low after 3 of 10 bytes.
  - Response: all outputs return to reset values immediately, no frame_done, and the next descriptor is accepted normally.
- Checksum (FRAME_READER_CSUM_EN):
  - Stimulus: bytes 45,00,00,1C,00.
  - Response: csum = 0x4500+0x001C+0x0000 = 0x451C at frame_done.
